demux14_dual_stream: RTL and testbench
======================================

// Module: demux14_dual_stream
// PURPOSE
//   1-to-4 stream demultiplexer, the inverse of the 4:1 dual-bit key mux: one W-bit input stream is routed to one of four output lanes by the 2-bit select Y.
//   Each lane has a one-entry output register with a valid/ready handshake, so every lane is backpressured independently.
//   Per-lane delivery counters are provided for debug and for bench scoreboarding.
//   Sits between a single producer and four independent consumers.
// PARAMETERS
//   W      2   data width of D and F0..F3
//   CNT_W  4   width of each per-lane delivery counter
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous reset, active low
//   D          in   W          input data
//   Y          in   2          destination lane select (0..3)
//   in_valid   in   1          producer has D/Y valid
//   in_ready   out  1          block can accept this cycle
//   F0..F3     out  W each     lane output data registers
//   out_valid  out  4          bit k: lane k holds an item
//   out_ready  in   4          bit k: consumer k accepts this cycle
//   cnt        out  4*CNT_W    lane k count = cnt[k*CNT_W +: CNT_W]
// BEHAVIOUR
//   Reset (rst_n=0, async):
//     - out_valid=0, F0..F3=0, all counters 0.
//     - in_ready forced 0 while rst_n=0.
//   Accept: in_valid && in_ready on a clk edge.
//     - in_ready = rst_n && (!out_valid[Y] || out_ready[Y]); combinational.
//     - in_ready depends on Y even when in_valid=0, never on in_valid.
//   Latency: an item accepted at edge N appears on F[Y] with out_valid[Y]=1 after edge N; one cycle.
//   Lane k register, per edge:
//     - load only (accept with Y=k, no pop): F_k<=D, out_valid[k]<=1.
//     - pop only (out_valid[k]&&out_ready[k], no load): out_valid[k]<=0, F_k holds.
//     - load and pop in same cycle: F_k<=D, out_valid[k] stays 1; no bubble, no loss.
//     - neither: hold.
//   Data stability: F_k is stable while out_valid[k]=1 and out_ready[k]=0.
//   Lane independence:
//     - Lanes never share storage; a stalled lane never blocks accepts to other lanes.
//     - Pops on several lanes in one cycle are all honoured.
//   Counters:
//     - Lane k counter increments on every lane-k output handshake (out_valid&&out_ready).
//     - Wraps modulo 2^CNT_W with no saturation and no flag.
//   Boundary cases:
//     - out_ready[k] while out_valid[k]=0: ignored; counter unchanged.
//     - Y changes while in_valid=0: no effect on state.
//     - Reset mid-transfer: all held items discarded, counters cleared.
//     - First edge after release: behaves as empty.
//   No FSM beyond the four per-lane valid bits; ordering is preserved per lane, and no ordering is defined across lanes.
// TESTING
//   1 Reset:
//     - rst_n=0 with in_valid=1 -> in_ready=0, out_valid=4'b0000, cnt=0.
//     - Release -> in_ready=1.
//   2 Routing:
//     - D=2'b01,Y=0; D=2'b10,Y=1; D=2'b11,Y=2; D=2'b00,Y=3; all out_ready=1.
//     - Expected: each F_k carries its value one cycle after accept, and each lane count ends at 1.
//   3 Backpressure:
//     - out_ready[2]=0, send D=2'b11 then D=2'b01 to Y=2 -> second beat sees in_ready=0.
//     - Meanwhile D=2'b10 to Y=0 is accepted.
//     - Expected: F2 stays 2'b11 until out_ready[2]=1.
//   4 Back-to-back on one lane:
//     - out_ready[1]=1, 6 consecutive beats to Y=1 -> in_ready stays 1 and out_valid[1] stays 1.
//     - Expected: F1 carries the sequence in order.
//   5 Wrap: 17 pops on lane 3 with CNT_W=4 -> lane-3 count=1; other lanes 0.
//   6 Mid-operation reset: lanes 0 and 3 full, assert rst_n=0 between edges -> out_valid=0 immediately, F=0, cnt=0.

Source files
------------

// File: rtl/demux14_dual_stream_if.sv
// Stream bundle for the 1:4 demultiplexer: one producer-side stream, four consumer lanes.
// The block uses the slave modport; the producer/consumer environment uses master.
interface demux14_dual_stream_if #(
    parameter int unsigned W     = 2,
    parameter int unsigned CNT_W = 4
) ();
    logic [W-1:0]       D;
    logic [1:0]         Y;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       F0;
    logic [W-1:0]       F1;
    logic [W-1:0]       F2;
    logic [W-1:0]       F3;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*CNT_W-1:0] cnt;

    modport slave (
        input  D, Y, in_valid, out_ready,
        output in_ready, F0, F1, F2, F3, out_valid, cnt
    );

    modport master (
        output D, Y, in_valid, out_ready,
        input  in_ready, F0, F1, F2, F3, out_valid, cnt
    );
endinterface

// File: rtl/demux14_dual_stream.sv
// 1-to-4 stream demultiplexer with a one-entry register per lane and per-lane
// delivery counters; each lane is backpressured independently.
module demux14_dual_stream #(
    parameter int unsigned W     = 2,
    parameter int unsigned CNT_W = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    demux14_dual_stream_if.slave bus
);

    logic [3:0][W-1:0]     f_q, f_d;
    logic [3:0]            valid_q, valid_d;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]            load, pop;
    logic                  in_ready;
    logic                  accept;

    // A full lane can still take a new item in the same cycle it is being drained.
    assign in_ready = rst_n && (!valid_q[bus.Y] || bus.out_ready[bus.Y]);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        load    = '0;
        pop     = '0;
        valid_d = valid_q;
        f_d     = f_q;
        cnt_d   = cnt_q;
        for (int k = 0; k < 4; k++) begin
            load[k] = accept && (bus.Y == 2'(k));
            pop[k]  = valid_q[k] && bus.out_ready[k];
            if (load[k]) begin
                f_d[k]     = bus.D;
                valid_d[k] = 1'b1;
            end else if (pop[k]) begin
                valid_d[k] = 1'b0;
            end
            if (pop[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q     <= '0;
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            f_q     <= f_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.F0        = f_q[0];
    assign bus.F1        = f_q[1];
    assign bus.F2        = f_q[2];
    assign bus.F3        = f_q[3];
    assign bus.out_valid = valid_q;
    assign bus.cnt       = cnt_q;

endmodule

// File: tb/tb_demux14_dual_stream.sv
// Directed bench for demux14_dual_stream: per-lane queue model checked every
// negedge, plus hand-computed literal expectations in each scenario.
module tb_demux14_dual_stream;

    localparam int unsigned W     = 2;
    localparam int unsigned CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   passed = 0;
    int   total = 0;

    demux14_dual_stream_if #(.W(W), .CNT_W(CNT_W)) bus ();

    demux14_dual_stream #(.W(W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: each lane is a queue of pending items, plus last-loaded data and a delivery tally.
    logic [W-1:0] lane_q [4][$];
    logic [W-1:0] last_d [4];
    int           delivered [4];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            lane_q[k].delete();
            last_d[k]    = '0;
            delivered[k] = 0;
        end
    endtask

    function automatic logic exp_in_ready();
        return rst_n && (lane_q[bus.Y].size() == 0 || bus.out_ready[bus.Y]);
    endfunction

    function automatic logic [W-1:0] get_f(int k);
        case (k)
            0:       return bus.F0;
            1:       return bus.F1;
            2:       return bus.F2;
            default: return bus.F3;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] get_cnt(int k);
        return bus.cnt[k*CNT_W +: CNT_W];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    initial begin
        model_reset();
        forever begin
            logic acc;
            @(posedge clk);
            if (rst_n) begin
                acc = bus.in_valid && exp_in_ready();
                for (int k = 0; k < 4; k++) begin
                    if (lane_q[k].size() > 0 && bus.out_ready[k]) begin
                        void'(lane_q[k].pop_front());
                        delivered[k]++;
                    end
                end
                if (acc) begin
                    lane_q[bus.Y].push_back(bus.D);
                    last_d[bus.Y] = bus.D;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready", 32'(bus.in_ready), 32'(exp_in_ready()));
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("out_valid[%0d]", k), 32'(bus.out_valid[k]),
                    32'(lane_q[k].size() > 0));
                chk($sformatf("F%0d", k), 32'(get_f(k)), 32'(last_d[k]));
                chk($sformatf("cnt[%0d]", k), 32'(get_cnt(k)), 32'(delivered[k] % 16));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic beat(input logic [1:0] d, input logic [1:0] y);
        bus.D        = d;
        bus.Y        = y;
        bus.in_valid = 1'b1;
    endtask

    logic [1:0] seq4 [6];

    initial begin
        bus.D         = '0;
        bus.Y         = '0;
        bus.in_valid  = 1'b1;
        bus.out_ready = '0;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst cnt", 32'(bus.cnt), 32'h0);
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("release in_ready", 32'(bus.in_ready), 32'h1);

        // Routing
        tick();
        bus.out_ready = 4'hf;
        beat(2'b01, 2'd0); tick(); chk("route F0", 32'(bus.F0), 32'h1);
        beat(2'b10, 2'd1); tick(); chk("route F1", 32'(bus.F1), 32'h2);
        beat(2'b11, 2'd2); tick(); chk("route F2", 32'(bus.F2), 32'h3);
        beat(2'b00, 2'd3); tick(); chk("route F3", 32'(bus.F3), 32'h0);
        chk("route v3", 32'(bus.out_valid), 32'h8);
        bus.in_valid = 1'b0;
        tick();
        chk("route cnt", 32'(bus.cnt), 32'h1111);

        // Backpressure
        bus.out_ready = 4'b1011;
        do_reset();
        beat(2'b11, 2'd2); tick();
        beat(2'b01, 2'd2); #1;
        chk("bp in_ready stall", 32'(bus.in_ready), 32'h0);
        tick();
        chk("bp F2 held", 32'(bus.F2), 32'h3);
        beat(2'b10, 2'd0); #1;
        chk("bp lane0 ready", 32'(bus.in_ready), 32'h1);
        tick();
        chk("bp F0", 32'(bus.F0), 32'h2);
        chk("bp F2 still", 32'(bus.F2), 32'h3);
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("bp F2 stable", 32'(bus.F2), 32'h3);
        chk("bp v", 32'(bus.out_valid), 32'h4);
        bus.out_ready = 4'hf;
        beat(2'b01, 2'd2); #1;
        chk("bp pop+load ready", 32'(bus.in_ready), 32'h1);
        tick();
        chk("bp F2 new", 32'(bus.F2), 32'h1);
        bus.in_valid = 1'b0;
        tick();
        chk("bp cnt", 32'(bus.cnt), 32'h0201);

        // Back-to-back on lane 1
        bus.out_ready = 4'b0010;
        do_reset();
        seq4 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        for (int i = 0; i < 6; i++) begin
            beat(seq4[i], 2'd1); #1;
            chk("b2b in_ready", 32'(bus.in_ready), 32'h1);
            tick();
            chk("b2b v1", 32'(bus.out_valid[1]), 32'h1);
            chk("b2b F1", 32'(bus.F1), 32'(seq4[i]));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("b2b cnt", 32'(bus.cnt), 32'h0060);

        // Counter wrap on lane 3
        bus.out_ready = 4'b1000;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            beat(2'(i), 2'd3);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        chk("wrap cnt", 32'(bus.cnt), 32'h1000);

        // Mid-operation reset, with Y wandering while idle first
        bus.out_ready = 4'b0000;
        do_reset();
        beat(2'b10, 2'd0); tick();
        beat(2'b01, 2'd3); tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.Y = 2'(i);
            tick();
        end
        chk("mid v", 32'(bus.out_valid), 32'h9);
        chk("mid F0", 32'(bus.F0), 32'h2);
        chk("mid F3", 32'(bus.F3), 32'h1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid rst v", 32'(bus.out_valid), 32'h0);
        chk("mid rst F", 32'({bus.F3, bus.F2, bus.F1, bus.F0}), 32'h0);
        chk("mid rst cnt", 32'(bus.cnt), 32'h0);
        chk("mid rst in_ready", 32'(bus.in_ready), 32'h0);
        #1;
        rst_n = 1'b1;
        bus.Y = 2'd3;
        #1;
        chk("post rst in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        chk("post rst v", 32'(bus.out_valid), 32'h0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
